div_unit: RTL and testbench
===========================

# div_unit

Sequential 32-bit signed divider for the multicycle CPU datapath. Executes the `div` instruction over a fixed number of cycles using restoring division. Produces quotient (`lo`) and remainder (`hi`) registers that feed the HI/LO inputs of the write-back selection muxes downstream. It is started by the control unit and reports completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; only 32 is supported.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a division; sampled only when `busy`=0.
- `dividend`  in  32  signed dividend, captured on the accepted `start` edge.
- `divisor`  in  32  signed divisor, captured on the accepted `start` edge.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `div_zero`  out  1  divide-by-zero flag (see Configuration).
- `hi`  out  32  remainder; holds its value until the next completion.
- `lo`  out  32  quotient; holds its value until the next completion.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, `start`=1:
  - Capture |dividend| and |divisor|, plus the signs of both operands.
  - Clear the partial remainder and set count=0.
  - Go to RUN.
- RUN, one quotient bit per cycle:
  - Shift the {remainder, quotient} pair left by 1.
  - Trial-subtract the divisor using a 33-bit subtract.
  - If the result is non-negative, keep it and set the quotient LSB.
  - count increments each cycle; after count=31, go to FIX.
- FIX:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - Load `hi`/`lo` at the FIX→DONE edge.
- DONE: `done`=1 for this one cycle, then return to IDLE.
- Semantics match MIPS `div`:
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
- Overflow: 0x80000000 / -1 gives `lo`=0x80000000 and `hi`=0. This is the natural two's-complement wrap and raises no flag.
- `start` while `busy`=1 is ignored. The running operation is not disturbed.
- Reset, asserted at any time including mid-operation:
  - State returns to IDLE.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0.
  - No partial result is ever written.

## Timing
- `start` accepted at edge k:
  - RUN covers cycles k+1..k+32.
  - FIX is cycle k+33.
  - `done` is high during cycle k+34.
- Latency is therefore 34 cycles, start edge to the `done` cycle.
- `busy` is high during cycles k+1..k+34.
- A new `start` is accepted in the cycle after DONE at the earliest.
- `hi`/`lo` change only at the edge entering DONE, or on reset.
- `start` asserted during the `done` cycle itself is ignored, because the state is not IDLE.

## Configuration
- `DIV_ZERO_EXC_EN` defined:
  - A divisor of 0 at `start` goes IDLE→DONE directly, so `done` is high at cycle k+1.
  - `div_zero`=1 for that same cycle only.
  - `hi`/`lo` are left unchanged.
- `DIV_ZERO_EXC_EN` undefined:
  - A divisor of 0 runs the full 34-cycle sequence.
  - The result is forced to `lo`=0 and `hi`=dividend.
  - `div_zero` is tied to 0.

## Structure
- Shared package `cpu_pkg` holds:
  - the state encoding of `div_unit` as a 2-bit enum (IDLE=0, RUN=1, FIX=2, DONE=3);
  - `DATA_W`=32;
  - `DIV_CNT_W`=5.
- No sub-module: the iteration step and sign fix are inline. Absolute value and negation share one local function.

## Test plan
- Reset mid-run: assert `reset`=0 at cycle k+10 → `busy`=0, `hi`=`lo`=0. A following `start` of 7/2 completes normally.
- Basic: 100 / 7 → `done` at k+34, `lo`=14, `hi`=2; `busy` high for exactly 34 cycles.
- Signs:
  - -7 / 2 → `lo`=-3 (0xFFFFFFFD), `hi`=-1 (0xFFFFFFFF).
  - 7 / -2 → `lo`=-3, `hi`=1.
- Overflow and busy: 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. A second `start` pulsed at k+5 is ignored and the result is unchanged.
- Divide-by-zero with `DIV_ZERO_EXC_EN`: 5 / 0 → `done`=`div_zero`=1 at k+1, and `hi`/`lo` keep their previous values.
- Divide-by-zero without `DIV_ZERO_EXC_EN`: 5 / 0 → `done` at k+34, `lo`=0, `hi`=5, `div_zero`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: data width and the div_unit state encoding.
package cpu_pkg;

  localparam int DATA_W    = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Sequential 32-bit signed restoring divider (MIPS div semantics): lo = quotient, hi = remainder.
// Optional feature macro: DIV_ZERO_EXC_EN (divide-by-zero completes in one cycle and flags div_zero).
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  div_state_t           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     dsr;
  logic                 neg_q;
  logic                 neg_r;
  logic                 dz;

  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dsr};
  end

`ifndef DIV_ZERO_EXC_EN
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dsr   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef DIV_ZERO_EXC_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
      div_zero <= 1'b0;
`endif
      case (state)
        DIV_IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef DIV_ZERO_EXC_EN
            if (divisor == '0) begin
              state    <= DIV_DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else
`endif
            begin
              quo   <= cond_neg(dividend, dividend[WIDTH-1]);
              dsr   <= cond_neg(divisor, divisor[WIDTH-1]);
              rem   <= '0;
              cnt   <= '0;
              neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r <= dividend[WIDTH-1];
              dz    <= (divisor == '0);
              state <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          // shifted < 2^WIDTH always, so diff[WIDTH] is a true borrow flag
          rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          cnt <= cnt + 1'b1;
          if (cnt == DIV_CNT_W'(WIDTH - 1)) state <= DIV_FIX;
        end
        DIV_FIX: begin
          // With a zero divisor every trial succeeds, so rem ends up holding |dividend|
          // and the sign fix restores the original dividend for hi.
          lo    <= dz ? '0 : cond_neg(quo, neg_q);
          hi    <= cond_neg(rem, neg_r);
          done  <= 1'b1;
          state <= DIV_DONE;
        end
        DIV_DONE: begin
          busy  <= 1'b0;
          state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed scenarios plus randomized operands vs. an arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DIV_ZERO_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // MIPS div reference: truncating quotient, remainder with dividend's sign, 32-bit wrap.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      el = 32'd0;
      eh = a;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      el = q[31:0];
      eh = r[31:0];
    end
  endfunction

  // Issue one division and observe latency, busy cycles, div_zero at done, busy after done.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output int bcnt, output logic dz, output logic bafter);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = -1;
    bcnt = 0;
    dz   = 1'b0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        dz  = div_zero;
      end
    end
    @(negedge clk);
    bafter = busy;
  endtask

  task automatic test_reset();
    int lat, bcnt;
    logic dz, ba;
    bit seen;
    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, div_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: busy/done/dz=%b%b%b hi=%h lo=%h, want 000 0 0", busy, done, div_zero, hi, lo);
    end
    reset = 1'b1;
    do_div(32'd7, 32'd3, lat, bcnt, dz, ba);
    n_cmp++;
    if (lo !== 32'd2 || hi !== 32'd1) begin
      n_bad++; $display("FAIL pre_reset_op: lo=%h hi=%h want 2 1", lo, hi);
    end
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++; $display("FAIL reset_midrun: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++; $display("FAIL reset_no_partial: activity=%b hi=%h lo=%h want 0 0 0", seen, hi, lo);
    end
    do_div(32'd7, 32'd2, lat, bcnt, dz, ba);
    n_cmp++;
    if (lat !== 34 || lo !== 32'd3 || hi !== 32'd1) begin
      n_bad++; $display("FAIL post_reset_op: lat=%0d lo=%h hi=%h want 34 3 1", lat, lo, hi);
    end
  endtask

  task automatic test_basic();
    int lat, bcnt;
    logic dz, ba;
    do_div(32'd100, 32'd7, lat, bcnt, dz, ba);
    n_cmp++;
    if (lat !== 34) begin n_bad++; $display("FAIL basic_latency: got %0d want 34", lat); end
    n_cmp++;
    if (bcnt !== 34 || ba !== 1'b0) begin
      n_bad++; $display("FAIL basic_busy: cycles=%0d after=%b want 34 0", bcnt, ba);
    end
    n_cmp++;
    if (lo !== 32'd14 || hi !== 32'd2 || dz !== 1'b0) begin
      n_bad++; $display("FAIL basic_result: lo=%h hi=%h dz=%b want e 2 0", lo, hi, dz);
    end
  endtask

  task automatic test_signs();
    logic [31:0] ta [4] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h7FFF_FFFF};
    logic [31:0] tb [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h8000_0000};
    logic [31:0] eh_t [4] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] el_t [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3, 32'd0};
    int lat, bcnt;
    logic dz, ba;
    for (int i = 0; i < 4; i++) begin
      do_div(ta[i], tb[i], lat, bcnt, dz, ba);
      n_cmp++;
      if (lo !== el_t[i] || hi !== eh_t[i] || lat !== 34) begin
        n_bad++;
        $display("FAIL signs[%0d] %h/%h: lo=%h hi=%h lat=%0d want lo=%h hi=%h lat=34",
                 i, ta[i], tb[i], lo, hi, lat, el_t[i], eh_t[i]);
      end
    end
  endtask

  task automatic test_overflow_busy();
    int lat;
    lat = -1;
    @(negedge clk);
    dividend = 32'h8000_0000; divisor = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 5) begin start = 1'b1; dividend = 32'd9; divisor = 32'd3; end
      if (n == 6) start = 1'b0;
      if (done) lat = n;
    end
    n_cmp++;
    if (lat !== 34 || lo !== 32'h8000_0000 || hi !== 32'd0) begin
      n_bad++; $display("FAIL overflow_busy: lat=%0d lo=%h hi=%h want 34 80000000 0", lat, lo, hi);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL overflow_restart: busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic dz, ba;
    lat = -1;
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd33; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n; start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (lat !== 34 || busy !== 1'b0 || lo !== 32'd30 || hi !== 32'd10) begin
      n_bad++;
      $display("FAIL start_in_done: lat=%0d busy=%b lo=%h hi=%h want 34 0 1e a", lat, busy, lo, hi);
    end
    do_div(32'd50, 32'd5, lat, bcnt, dz, ba);
    n_cmp++;
    if (lat !== 34 || lo !== 32'd10 || hi !== 32'd0) begin
      n_bad++; $display("FAIL back_to_back: lat=%0d lo=%h hi=%h want 34 a 0", lat, lo, hi);
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    logic dz, ba;
    do_div(32'd100, 32'd7, lat, bcnt, dz, ba);
    do_div(32'd5, 32'd0, lat, bcnt, dz, ba);
    n_cmp++;
    if (EXC) begin
      if (lat !== 1 || dz !== 1'b1 || hi !== 32'd2 || lo !== 32'd14 || ba !== 1'b0) begin
        n_bad++;
        $display("FAIL div_zero_exc: lat=%0d dz=%b hi=%h lo=%h after=%b want 1 1 2 e 0", lat, dz, hi, lo, ba);
      end
    end else begin
      if (lat !== 34 || dz !== 1'b0 || hi !== 32'd5 || lo !== 32'd0) begin
        n_bad++;
        $display("FAIL div_zero_noexc: lat=%0d dz=%b hi=%h lo=%h want 34 0 5 0", lat, dz, hi, lo);
      end
    end
    n_cmp++;
    if (div_zero !== 1'b0) begin n_bad++; $display("FAIL div_zero_pulse: dz=%b want 0", div_zero); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, eh, el, ph, pl;
    int lat, bcnt, elat;
    logic dz, ba;
    ph = hi; pl = lo;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = -$urandom_range(1, 255);
        3: b = (i % 2) ? 32'hFFFF_FFFF : 32'd1;
        default: b = (i % 3 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      endcase
      if (i == 7) a = 32'h8000_0000;
      if (b == 32'd0 && EXC) begin
        eh = ph; el = pl; elat = 1;
      end else begin
        ref_div(a, b, eh, el); elat = 34;
      end
      do_div(a, b, lat, bcnt, dz, ba);
      n_cmp++;
      if (lo !== el || hi !== eh || lat !== elat) begin
        n_bad++;
        $display("FAIL random[%0d] %h/%h: lo=%h hi=%h lat=%0d want lo=%h hi=%h lat=%0d",
                 i, a, b, lo, hi, lat, el, eh, elat);
      end
      ph = eh; pl = el;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_overflow_busy();
    test_back_to_back();
    test_div_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
